// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the seven-segment scan display: segment bit positions,
// digit count and the hexadecimal glyph table.
package seg_pkg;

  localparam int NDIGITS = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry n is the a..g pattern for hex digit n (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
    return HEX_FONT[nibble];
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Core-side write port of the scan display: value, decimal points, strobe
// and the pending-commit indication returned to the core.
interface seg_scan_display_if;
  logic [31:0] val;
  logic [7:0]  dp;
  logic        val_valid;
  logic        busy;

  modport master (output val, output dp, output val_valid, input busy);
  modport slave  (input val, input dp, input val_valid, output busy);
endinterface

// File: rtl/seg_scan_display_hex_font.sv
// One digit of the display: hex glyph plus decimal point, forced dark when
// the digit is blanked.
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = '0;
    if (!blank) begin
      pattern[SEG_G:SEG_A] = hex7seg(nibble);
      pattern[SEG_DP]      = dp;
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed seven-segment driver with a shadow register that
// only commits new values on scan-frame boundaries.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int PRESCALE   = 1024,
  parameter int LZB        = 0,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_display_if.slave   core,
  output logic [63:0]         seg_out,
  output logic [7:0]          seg_sel
);

  localparam int              PC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(PRESCALE - 1);
  localparam logic [2:0]      IDX_MAX = 3'(NDIGITS - 1);

  logic [PC_W-1:0] pc_cnt_q, pc_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [31:0]     pend_val_q, pend_val_d;
  logic [7:0]      pend_dp_q, pend_dp_d;
  logic [31:0]     disp_val_q, disp_val_d;
  logic [7:0]      disp_dp_q, disp_dp_d;
  logic [63:0]     seg_out_q, seg_out_d;
  logic [7:0]      seg_sel_q, seg_sel_d;

  logic            tick;
  logic            frame_end;
  logic [2:0]      msn;
  logic [7:0]      blank;
  logic [63:0]     font_pat;

  always_comb begin
    tick      = (pc_cnt_q == PC_MAX);
    frame_end = tick && (idx_q == IDX_MAX);
    pc_cnt_d  = tick ? '0 : pc_cnt_q + PC_W'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;

    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    // A strobe landing on the frame boundary bypasses the shadow register.
    if (core.val_valid && frame_end) begin
      disp_val_d = core.val;
      disp_dp_d  = core.dp;
      pend_d     = 1'b0;
    end else if (core.val_valid) begin
      pend_val_d = core.val;
      pend_dp_d  = core.dp;
      pend_d     = 1'b1;
    end else if (frame_end && pend_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pend_d     = 1'b0;
    end

    seg_sel_d = 8'b1 << idx_d;
    seg_out_d = font_pat;
  end

  // Digit 0 always shows, so the search for the top non-zero nibble starts at 1.
  always_comb begin
    msn   = '0;
    blank = '0;
    for (int i = 1; i < NDIGITS; i++) begin
      if (disp_val_q[4*i +: 4] != 4'h0) msn = 3'(i);
    end
    for (int i = 0; i < NDIGITS; i++) begin
      blank[i] = (LZB != 0) && (3'(i) > msn);
    end
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    seg_hex_font u_font (
      .nibble  (disp_val_q[4*g +: 4]),
      .dp      (disp_dp_q[g]),
      .blank   (blank[g]),
      .pattern (font_pat[8*g +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_cnt_q   <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_out_q  <= '0;
      seg_sel_q  <= 8'h01;
    end else begin
      pc_cnt_q   <= pc_cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_out_q  <= seg_out_d;
      seg_sel_q  <= seg_sel_d;
    end
  end

  // Shadow data is only meaningful while pend_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_val_q <= pend_val_d;
    pend_dp_q  <= pend_dp_d;
  end

  assign seg_out   = (ACTIVE_LOW != 0) ? ~seg_out_q : seg_out_q;
  assign seg_sel   = (ACTIVE_LOW != 0) ? ~seg_sel_q : seg_sel_q;
  assign core.busy = pend_q;

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Output stage of the processor board: consumes a 32-bit value and decimal-point mask from the core (register/ALU result, strobed at the write phase), holds it in a tear-free shadow register, and drives the eight-digit seven-segment interface `seg_out[63:0]` / `seg_sel[7:0]`. Updates are deferred to scan-frame boundaries so a digit never shows a mix of old and new data. Leading-zero blanking and output polarity are selectable.

## Interface
- `PRESCALE`, 1024: clock cycles per digit scan slot; legal range ≥ 1.
- `LZB`, 0: 1 enables leading-zero blanking.
- `ACTIVE_LOW`, 0: 1 inverts `seg_out` and `seg_sel`.

- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `val` in 32: value to display; nibble i → digit i (digit 0 = rightmost).
- `dp` in 8: decimal-point mask; bit i → digit i.
- `val_valid` in 1: single-cycle strobe; captures `val` and `dp`.
- `seg_out` out 64: digit i pattern in bits [8i+7:8i]; bit0..6 = a..g, bit7 = dp.
- `seg_sel` out 8: one-hot scan enable for the multiplexed board wiring.
- `busy` out 1: high while a captured value awaits commit.

## Operation
- Registers: `pend_val[31:0]`, `pend_dp[7:0]`, `pend` flag, `disp_val`, `disp_dp`, prescale counter `pc_cnt` (0..PRESCALE-1), scan index `idx[2:0]`.
- Capture: `val_valid`=1 loads pend_val/pend_dp and sets `pend`. Repeated strobes before commit overwrite; the last strobe wins.
- Tick: `pc_cnt` counts 0..PRESCALE-1 and wraps; `tick` = (pc_cnt == PRESCALE-1). On `tick`, `idx` advances and wraps 7→0.
- Frame end: `tick` with idx==7. On frame end with `pend`=1: disp ← pend, `pend` cleared.
- Simultaneous strobe and frame end: the strobed `val`/`dp` commit directly to disp, and `pend` ends at 0.
- Decode: each digit uses the hex font 0–F; dp bit ORed into bit7.
- Blanking (LZB=1): digits above the most significant non-zero nibble show all segments off, dp bits included. Digit 0 is never blanked. val=0 shows a single "0".
- `seg_sel` is one-hot at bit `idx`. `ACTIVE_LOW`=1 inverts both outputs bitwise, including in reset.
- `busy` = `pend`.

## Timing
- Reset values (ACTIVE_LOW=0): `seg_out`=64'h0, `seg_sel`=8'h01, `busy`=0, disp=0, pend=0, pc_cnt=0, idx=0.
- `rst` mid-frame or with `pend`=1 discards the pending value. Reset dominates a coincident `val_valid`.
- `seg_out` is registered from disp and changes on the edge after disp changes. First decode ("00000000", or "0" with LZB) appears one cycle after `rst` falls.
- Latency from strobe to `seg_out`: between 2 and 8·PRESCALE+1 cycles.
- `seg_sel` is registered and changes on the edge after `tick`. A full frame is 8·PRESCALE cycles.
- PRESCALE=1: `tick` every cycle and `seg_sel` rotates every cycle.

## Structure
- Shared package `seg_pkg`:
  - segment bit positions SEG_A..SEG_G, SEG_DP;
  - `NDIGITS`=8;
  - 16-entry hex font constant and function `hex7seg(nibble) → [6:0]`.
- One combinational sub-module, `seg_hex_font`: nibble + dp + blank in, 8-bit pattern out. Instantiate eight times.
- Top contains prescaler, scan counter, pending/commit logic and output registers.

## Test plan
Run with PRESCALE=4.
1. Reset: `rst`=1 for 3 cycles, then release → `seg_out`=0 and `seg_sel`=01 during reset. One cycle later `seg_out`=64'h3F3F3F3F3F3F3F3F.
2. Strobe val=32'h1234ABCD, dp=8'h00 at cycle 5 → `busy`=1 until frame end at cycle 31; `seg_out` digit 0 = 8'h5E (d) and digit 7 = 8'h06 (1) at cycle 33.
3. Strobe 32'h11111111, then 32'h22222222 two cycles later, both before frame end → only `2222_2222` is ever displayed, every digit 8'h5B.
4. Strobe coincident with frame-end tick → committed that edge, `busy` never asserts, `seg_out` updates the next cycle.
5. LZB=1, val=32'h0000_00F0, dp=8'h04 → digits 0–1 = 3F, 71; digit 2 = 00 (blanked, dp suppressed); digits 3–7 = 00. Then val=0 → only digit 0 = 3F.
6. `rst` asserted while `busy`=1, mid-frame → pending value lost, `seg_sel`=01 next cycle, display stays 0; ACTIVE_LOW=1 variant gives `seg_sel`=8'hFE and `seg_out`=all ones.
